load_size_reader: RTL and testbench

Load-side counterpart of the store byte/half/word merge unit in the multicycle datapath. On a start request it issues one memory read, waits a fixed memory latency, captures the returned word and extracts the low byte, halfword or full word selected by a 2-bit size code, zero- or sign-extended to 32 bits. The result goes to the register-file write-back mux. Both blocks use the same size encoding and the same low-order lane, so a store followed by a load of the same size round-trips.

---
 rtl/load_size_reader_if.sv | 46 ++++
 rtl/load_size_reader.sv | 119 +++++++++++
 tb/tb_load_size_reader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_size_reader_if.sv
// ============================================================================
// Module      : load_size_reader_if
// Description : Bundles the load request, memory read and result signals of
//               the load size reader.
//               slave  - the load size reader itself
//               master - the requester / memory side driving it
//   start      : load request (sampled when not busy)
//   addr       : load address
//   lsrcontrol : size code 00=byte 01=half 10=word 11=illegal
//   sign_ext   : 1 = sign-extend byte/half result
//   mem_rd     : memory read strobe
//   mem_addr   : memory read address
//   mem_rdata  : memory read data
//   out        : extracted, extended load result
//   busy       : load in flight
//   done       : one-cycle completion pulse
//   err        : one-cycle pulse with done for an illegal size code
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_size_reader_if;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  lsrcontrol;
    logic        sign_ext;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, addr, lsrcontrol, sign_ext, mem_rdata,
        output mem_rd, mem_addr, out, busy, done, err
    );

    modport master (
        output start, addr, lsrcontrol, sign_ext, mem_rdata,
        input  mem_rd, mem_addr, out, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/load_size_reader.sv
// ============================================================================
// Module      : load_size_reader
// Description : Issues one memory read per accepted load request, waits a
//               fixed memory latency, then returns the low byte, halfword or
//               full word of the read data, zero- or sign-extended to 32 bits.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : load_size_reader_if.slave (request, memory and result signals)
//   MEM_LATENCY: cycles from the mem_rd cycle to valid mem_rdata (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_size_reader #(
    parameter int MEM_LATENCY = 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    load_size_reader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  lsr_q;
    logic        sext_q;
    logic [3:0]  cnt_q;
    logic [31:0] out_q;
    logic [31:0] out_d;
    logic        mem_rd_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    // Lane extraction uses the operands latched at start, never the live inputs.
    always_comb begin
        out_d = bus.mem_rdata;
        case (lsr_q)
            2'b00:   out_d = {{24{sext_q & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
            2'b01:   out_d = {{16{sext_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default: out_d = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            lsr_q    <= 2'b00;
            sext_q   <= 1'b0;
            cnt_q    <= 4'd0;
            out_q    <= 32'd0;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_READ: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        out_q   <= out_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all accept a new request, which gives
                    // back-to-back loads with no idle bubble.
                    if (bus.start) begin
                        addr_q <= bus.addr;
                        lsr_q  <= bus.lsrcontrol;
                        sext_q <= bus.sign_ext;
                        if (bus.lsrcontrol == 2'b11) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            mem_rd_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_READ;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = addr_q;
    assign bus.out      = out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_size_reader.sv
// ============================================================================
// Module      : tb_load_size_reader
// Description : Bench for load_size_reader. Two instances run side by side:
//               index 0 with MEM_LATENCY=1, index 1 with MEM_LATENCY=4.
//               A cycle-level model predicts mem_rd, busy, done, err and out
//               from the accepted requests; one process compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_size_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Stimulus side, per instance
    logic        st [2];
    logic [31:0] ad [2];
    logic [1:0]  ls [2];
    logic        sx [2];
    logic        rst_n [2];
    logic [31:0] word_next [2];

    // DUT outputs, per instance
    logic        o_rd [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_out [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic        o_err [2];

    // Model state, per instance
    int          m_rd [2];
    int          m_done [2];
    int          m_dat [2];
    logic        m_err [2];
    logic [31:0] m_out [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_word [2];
    logic [31:0] m_addr [2];
    int          rd_count [2];

    load_size_reader_if if_a ();
    load_size_reader_if if_b ();

    load_size_reader #(.MEM_LATENCY(1)) u_dut_a (.clk(clk), .reset_n(rst_n[0]), .bus(if_a.slave));
    load_size_reader #(.MEM_LATENCY(4)) u_dut_b (.clk(clk), .reset_n(rst_n[1]), .bus(if_b.slave));

    assign if_a.start      = st[0];
    assign if_a.addr       = ad[0];
    assign if_a.lsrcontrol = ls[0];
    assign if_a.sign_ext   = sx[0];
    assign if_b.start      = st[1];
    assign if_b.addr       = ad[1];
    assign if_b.lsrcontrol = ls[1];
    assign if_b.sign_ext   = sx[1];

    // Memory: the loaded word is presented only in its valid cycle, junk otherwise.
    assign if_a.mem_rdata = (cyc == m_dat[0]) ? m_word[0] : (32'hBAD0_0000 ^ 32'(cyc));
    assign if_b.mem_rdata = (cyc == m_dat[1]) ? m_word[1] : (32'hBAD0_0000 ^ 32'(cyc));

    assign o_rd[0] = if_a.mem_rd;   assign o_rd[1] = if_b.mem_rd;
    assign o_addr[0] = if_a.mem_addr; assign o_addr[1] = if_b.mem_addr;
    assign o_out[0] = if_a.out;     assign o_out[1] = if_b.out;
    assign o_busy[0] = if_a.busy;   assign o_busy[1] = if_b.busy;
    assign o_done[0] = if_a.done;   assign o_done[1] = if_b.done;
    assign o_err[0] = if_a.err;     assign o_err[1] = if_b.err;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Expected load result from plain arithmetic on the lane value.
    function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] sz,
                                              input logic s);
        int v;
        if (sz == 2'b00) begin
            v = int'(w & 32'hFF);
            if (s && v >= 128) v = v - 256;
            return 32'(v);
        end else if (sz == 2'b01) begin
            v = int'(w & 32'hFFFF);
            if (s && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return w;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", nm, i, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset(input int i);
        m_rd[i]   = -1000;
        m_done[i] = -1000;
        m_dat[i]  = -1000;
        m_err[i]  = 1'b0;
        m_out[i]  = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            rd_count[i] = 0;
            m_pend[i] = 32'd0;
            m_word[i] = 32'd0;
            m_addr[i] = 32'd0;
        end
    end

    // Single compare process: checks every instance every cycle, then advances the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                model_reset(i);
                chk("rst_rd",   i, {31'd0, o_rd[i]},   32'd0);
                chk("rst_busy", i, {31'd0, o_busy[i]}, 32'd0);
                chk("rst_done", i, {31'd0, o_done[i]}, 32'd0);
                chk("rst_err",  i, {31'd0, o_err[i]},  32'd0);
                chk("rst_out",  i, o_out[i],           32'd0);
                chk("rst_addr", i, o_addr[i],          32'd0);
            end else begin
                if (cyc == m_done[i] && !m_err[i]) m_out[i] = m_pend[i];
                chk("rd",   i, {31'd0, o_rd[i]},   {31'd0, cyc == m_rd[i]});
                chk("busy", i, {31'd0, o_busy[i]}, {31'd0, (cyc >= m_rd[i]) && (cyc < m_done[i])});
                chk("done", i, {31'd0, o_done[i]}, {31'd0, cyc == m_done[i]});
                chk("err",  i, {31'd0, o_err[i]},  {31'd0, (cyc == m_done[i]) && m_err[i]});
                chk("out",  i, o_out[i], m_out[i]);
                if (cyc == m_rd[i]) chk("mem_addr", i, o_addr[i], m_addr[i]);
                if (o_rd[i]) rd_count[i]++;
                if (st[i] && cyc >= m_done[i]) begin
                    m_addr[i] = ad[i];
                    if (ls[i] == 2'b11) begin
                        m_rd[i]   = -1000;
                        m_done[i] = cyc + 1;
                        m_err[i]  = 1'b1;
                    end else begin
                        m_rd[i]   = cyc + 1;
                        m_dat[i]  = cyc + 1 + lat_of(i);
                        m_done[i] = cyc + 2 + lat_of(i);
                        m_err[i]  = 1'b0;
                        m_word[i] = word_next[i];
                        m_pend[i] = m_extract(word_next[i], ls[i], sx[i]);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle with
    // the operand inputs scrambled, so a latch-on-start fault shows up.
    task automatic pulse(input int i, input logic [31:0] a, input logic [1:0] l,
                         input logic s, input logic [31:0] w);
        st[i] = 1'b1; ad[i] = a; ls[i] = l; sx[i] = s; word_next[i] = w;
        @(posedge clk); #1;
        st[i] = 1'b0; ad[i] = ~a; ls[i] = 2'b11; sx[i] = ~s;
    endtask

    task automatic wait_done(input int i, input int s, output int lat);
        int k;
        k = 0;
        while (!o_done[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!o_done[i]) chk("done_timeout", i, 32'd0, 32'd1);
        lat = cyc - s;
        @(posedge clk); #1;
    endtask

    task automatic run_load(input int i, input logic [31:0] a, input logic [1:0] l,
                            input logic s, input logic [31:0] w, input logic [31:0] exp);
        int s0, lat;
        s0 = cyc;
        pulse(i, a, l, s, w);
        wait_done(i, s0, lat);
        chk("lit_lat", i, 32'(lat), 32'(lat_of(i) + 2));
        chk("lit_out", i, o_out[i], exp);
    endtask

    int s, lat, rc;
    logic saw_done;

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ad[i] = 32'd0; ls[i] = 2'b00; sx[i] = 1'b0;
            rst_n[i] = 1'b0; word_next[i] = 32'd0;
        end
        repeat (3) @(posedge clk); #1;
        chk("lit_rst_out", 0, o_out[0], 32'd0);
        chk("lit_rst_busy", 1, {31'd0, o_busy[1]}, 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Word load, latency 1: mem_rd in cycle 1 only, done in cycle 3.
        s = cyc;
        pulse(0, 32'h0000_0100, 2'b10, 1'b0, 32'h8765_4321);
        chk("lit_t1_rd", 0, {31'd0, o_rd[0]}, 32'd1);
        chk("lit_t1_addr", 0, o_addr[0], 32'h0000_0100);
        @(posedge clk); #1;
        chk("lit_t1_rd_off", 0, {31'd0, o_rd[0]}, 32'd0);
        wait_done(0, s, lat);
        chk("lit_t1_lat", 0, 32'(lat), 32'd3);
        chk("lit_t1_out", 0, o_out[0], 32'h8765_4321);

        // Byte and half extensions.
        run_load(0, 32'h0000_0200, 2'b00, 1'b1, 32'h1234_56F0, 32'hFFFF_FFF0);
        run_load(0, 32'h0000_0204, 2'b00, 1'b0, 32'h1234_56F0, 32'h0000_00F0);
        run_load(0, 32'h0000_0208, 2'b01, 1'b1, 32'h0000_8001, 32'hFFFF_8001);
        run_load(0, 32'h0000_020C, 2'b01, 1'b0, 32'h0000_8001, 32'h0000_8001);
        run_load(0, 32'h0000_0210, 2'b00, 1'b1, 32'h0000_007F, 32'h0000_007F);

        // Latency 4 with a start pulse at cycle 2 that must be ignored.
        s = cyc; rc = rd_count[1];
        pulse(1, 32'h0000_0400, 2'b10, 1'b0, 32'h0BAD_F00D);
        @(posedge clk); #1;
        pulse(1, 32'h0000_0500, 2'b00, 1'b1, 32'h1111_1111);
        wait_done(1, s, lat);
        chk("lit_t3_lat", 1, 32'(lat), 32'd6);
        chk("lit_t3_rdcnt", 1, 32'(rd_count[1] - rc), 32'd1);
        chk("lit_t3_out", 1, o_out[1], 32'h0BAD_F00D);

        // Back-to-back: second start in the DONE cycle.
        s = cyc;
        pulse(1, 32'h0000_0600, 2'b01, 1'b1, 32'h0000_8001);
        repeat (5) @(posedge clk);
        #1;
        chk("lit_b2b_done1", 1, {31'd0, o_done[1]}, 32'd1);
        chk("lit_b2b_out1", 1, o_out[1], 32'hFFFF_8001);
        pulse(1, 32'h0000_0604, 2'b00, 1'b0, 32'h1234_56F0);
        chk("lit_b2b_rd2", 1, {31'd0, o_rd[1]}, 32'd1);
        chk("lit_b2b_addr2", 1, o_addr[1], 32'h0000_0604);
        wait_done(1, s, lat);
        chk("lit_b2b_lat", 1, 32'(lat), 32'd12);
        chk("lit_b2b_out2", 1, o_out[1], 32'h0000_00F0);

        // Illegal size: done+err next cycle, no read, out held.
        run_load(0, 32'h0000_0700, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rc = rd_count[0];
        pulse(0, 32'h0000_0704, 2'b11, 1'b0, 32'h5555_5555);
        chk("lit_ill_done", 0, {31'd0, o_done[0]}, 32'd1);
        chk("lit_ill_err", 0, {31'd0, o_err[0]}, 32'd1);
        chk("lit_ill_out", 0, o_out[0], 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        chk("lit_ill_err_off", 0, {31'd0, o_err[0]}, 32'd0);
        chk("lit_ill_rdcnt", 0, 32'(rd_count[0] - rc), 32'd0);
        chk("lit_ill_out2", 0, o_out[0], 32'hDEAD_BEEF);

        // Asynchronous reset during WAIT.
        pulse(1, 32'h0000_0800, 2'b10, 1'b0, 32'h1111_2222);
        @(posedge clk); #1;
        chk("lit_wait_busy", 1, {31'd0, o_busy[1]}, 32'd1);
        rst_n[1] = 1'b0;
        #1;
        chk("lit_ar_rd", 1, {31'd0, o_rd[1]}, 32'd0);
        chk("lit_ar_busy", 1, {31'd0, o_busy[1]}, 32'd0);
        chk("lit_ar_out", 1, o_out[1], 32'd0);
        @(posedge clk); #2;
        rst_n[1] = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_done[1]) saw_done = 1'b1;
        end
        chk("lit_ar_nodone", 1, {31'd0, saw_done}, 32'd0);
        @(posedge clk); #1;
        run_load(1, 32'h0000_0900, 2'b10, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
